// File: rtl/halve_tokens.sv
// halve_tokens: emits one output token per FACTOR input '1' tokens, buffering completed
// tokens in a saturating pending counter. Optional macro HALVE_TOKENS_PENDING_EN exposes pending/frac_level.
module halve_tokens #(
  parameter int FACTOR       = 2,
  parameter int MAX_PENDING  = 200,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b_ready,
  output logic b,
  output logic overflow,
  output logic residue
`ifdef HALVE_TOKENS_PENDING_EN
  ,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic [$clog2(FACTOR)-1:0]        frac_level
`endif
);

  localparam int FW = $clog2(FACTOR);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [FW-1:0] FRAC_LAST = FW'(FACTOR - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic [FW-1:0] frac, frac_next;
  logic [PW-1:0] pend, pend_next;
  logic [IW-1:0] idle, idle_next;
  logic          overflow_next, residue_next;
  logic          inc, dec, timeout;

  assign b   = (pend != '0) && !overflow;
  assign dec = b && b_ready;

  always_comb begin
    frac_next     = frac;
    idle_next     = '0;
    pend_next     = pend;
    overflow_next = overflow;
    residue_next  = residue;
    inc           = 1'b0;
    timeout       = 1'b0;

    if (a) begin
      if (frac == FRAC_LAST) begin
        frac_next = '0;
        inc       = 1'b1;
      end else begin
        frac_next = frac + FW'(1);
      end
    end else if (frac != '0) begin
      // a partial group waiting too long is discarded and reported
      if (idle == IDLE_LAST) begin
        timeout = 1'b1;
      end else begin
        idle_next = idle + IW'(1);
      end
    end

    if (timeout) begin
      frac_next    = '0;
      residue_next = 1'b1;
    end

    // once overflow is flagged the counter is frozen until reset
    if (!overflow) begin
      if (inc && !dec) begin
        if (pend == PEND_MAX) begin
          overflow_next = 1'b1;
        end else begin
          pend_next = pend + PW'(1);
        end
      end else if (dec && !inc) begin
        pend_next = pend - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frac     <= '0;
      pend     <= '0;
      idle     <= '0;
      overflow <= 1'b0;
      residue  <= 1'b0;
    end else begin
      frac     <= frac_next;
      pend     <= pend_next;
      idle     <= idle_next;
      overflow <= overflow_next;
      residue  <= residue_next;
    end
  end

`ifdef HALVE_TOKENS_PENDING_EN
  assign pending    = pend;
  assign frac_level = frac;
`endif

endmodule

// File: tb/tb_halve_tokens.sv
// tb_halve_tokens: directed test-plan sequences plus randomized traffic, all checked
// every cycle against an integer-count reference model of halve_tokens.
module tb_halve_tokens;

  localparam int FACTOR       = 2;
  localparam int MAX_PENDING  = 200;
  localparam int IDLE_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic a;
  logic b_ready;
  logic b;
  logic overflow;
  logic residue;
`ifdef HALVE_TOKENS_PENDING_EN
  logic [$clog2(MAX_PENDING+1)-1:0] pending;
  logic [$clog2(FACTOR)-1:0]        frac_level;
`endif

  int  err_count = 0;
  int  check_count = 0;
  bit  check_en = 1'b0;

  // reference model state, kept as plain counts
  int  m_frac = 0;
  int  m_pend = 0;
  int  m_idle = 0;
  bit  m_ovf = 1'b0;
  bit  m_res = 1'b0;

  halve_tokens #(
    .FACTOR(FACTOR),
    .MAX_PENDING(MAX_PENDING),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b_ready(b_ready),
    .b(b),
    .overflow(overflow),
    .residue(residue)
`ifdef HALVE_TOKENS_PENDING_EN
    ,
    .pending(pending),
    .frac_level(frac_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // inputs are set right after a falling edge and observed after the next one
  task automatic applyStimulus(input logic a_v, input logic rdy_v);
    a       = a_v;
    b_ready = rdy_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // model update from the token-counting rules
  always @(posedge clk) begin : model
    int  f, p, i;
    bit  o, r, inc, dec;
    if (rst) begin
      m_frac <= 0;
      m_pend <= 0;
      m_idle <= 0;
      m_ovf  <= 1'b0;
      m_res  <= 1'b0;
    end else begin
      f = m_frac; p = m_pend; i = m_idle; o = m_ovf; r = m_res;
      dec = (p > 0) && !o && b_ready;
      inc = 1'b0;
      if (a) begin
        f = f + 1;
        if (f == FACTOR) begin
          f   = 0;
          inc = 1'b1;
        end
        i = 0;
      end else if (m_frac == 0) begin
        i = 0;
      end else begin
        i = i + 1;
        if (i == IDLE_TIMEOUT) begin
          r = 1'b1;
          f = 0;
          i = 0;
        end
      end
      if (!o) begin
        if (inc && !dec) begin
          if (p == MAX_PENDING) o = 1'b1;
          else p = p + 1;
        end else if (dec && !inc) begin
          p = p - 1;
        end
      end
      m_frac <= f;
      m_pend <= p;
      m_idle <= i;
      m_ovf  <= o;
      m_res  <= r;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("b", int'(b), int'((m_pend != 0) && !m_ovf));
      checkOutput("overflow", int'(overflow), int'(m_ovf));
      checkOutput("residue", int'(residue), int'(m_res));
`ifdef HALVE_TOKENS_PENDING_EN
      checkOutput("pending", int'(pending), m_pend);
      checkOutput("frac_level", int'(frac_level), m_frac);
`endif
    end
  end

  initial begin
    logic [8:0] seq_a;
    logic [8:0] seq_b;
    int pulses;
    int mode;

    rst = 1'b1; a = 1'b0; b_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_b", int'(b), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_residue", int'(residue), 0);

    // basic halving, b listed per cycle before that cycle's edge
    seq_a = 9'b001111011;
    seq_b = 9'b010100100;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("basic_b[%0d]", i), int'(b), int'(seq_b[i]));
      applyStimulus(seq_a[i], 1'b1);
    end

    // backpressure
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("bp_model_pend", m_pend, 3);
    checkOutput("bp_b_held", int'(b), 1);
    seq_b = 9'b000000111;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_drain_b[%0d]", i), int'(b), int'(seq_b[i]));
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("bp_model_empty", m_pend, 0);

    // simultaneous completion and drain
    applyReset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("simul_b", int'(b), 1);
    checkOutput("simul_model_pend", m_pend, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("simul_after_b", int'(b), 0);

    // overflow
    applyReset();
    for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("ovf_model_pend", m_pend, 200);
    checkOutput("ovf_pre_flag", int'(overflow), 0);
    checkOutput("ovf_pre_b", int'(b), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ovf_flag", int'(overflow), 1);
    checkOutput("ovf_b", int'(b), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("ovf_b_stuck", int'(b), 0);
    applyReset();
    checkOutput("ovf_cleared", int'(overflow), 0);
    checkOutput("ovf_cleared_b", int'(b), 0);

    // residue timeout
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < IDLE_TIMEOUT - 1; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("res_before", int'(residue), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("res_after", int'(residue), 1);
    checkOutput("res_model_frac", m_frac, 0);
    pulses = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pulses += int'(b);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("res_one_pulse", pulses, 1);
    checkOutput("res_sticky", int'(residue), 1);

    // reset mid-operation
    applyReset();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < IDLE_TIMEOUT; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("mid_model_pend", m_pend, 5);
    checkOutput("mid_model_frac", m_frac, 1);
    checkOutput("mid_residue", int'(residue), 1);
    applyReset();
    checkOutput("mid_rst_b", int'(b), 0);
    checkOutput("mid_rst_residue", int'(residue), 0);
    checkOutput("mid_rst_overflow", int'(overflow), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_latency_wait", int'(b), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_latency_pulse", int'(b), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mid_latency_end", int'(b), 0);

    // randomized traffic in segments of differing input density
    for (int seg = 0; seg < 50; seg++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        case (mode)
          0:       applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
          1:       applyStimulus(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
          default: applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 8));
        endcase
      end
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
